// File: rtl/pc_sequencer.sv
// Program-counter sequencer: decodes flow-control instructions and steers the PC counter
// through jumps, call/return via a small return stack, timed waits and halts.
module pc_sequencer #(
  parameter int CounterBits = 6,
  parameter int StackDepth  = 4
) (
  input  logic                   CLK,
  input  logic                   CPU_SetReset,
  input  logic [CounterBits-1:0] PC_Counter,
  input  logic [15:0]            Instr,
  input  logic                   ALU_Zero,
  input  logic                   Resume,
  output logic                   PC_SetJmp,
  output logic [CounterBits-1:0] PC_JMPAddr,
  output logic                   PC_SetStop,
  output logic                   Halted,
  output logic                   StackFault
);

  // state        | meaning
  // StRun        | decoding one instruction per cycle
  // StWait       | dwelling on a WAIT, waitCnt counts down to zero
  // StHaltOp     | stopped by HALT, Resume advances past it
  // StHaltFault  | stack overflow/underflow, only reset exits
  typedef enum logic [1:0] {StRun, StWait, StHaltOp, StHaltFault} seqState_t;

  localparam int SpBits  = $clog2(StackDepth + 1);
  localparam int IdxBits = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  seqState_t              state, nextState;
  logic [SpBits-1:0]      stackPtr;
  logic [7:0]             waitCnt;
  logic [CounterBits-1:0] stackMem [2**IdxBits];

  logic [3:0]             opcode;
  logic [CounterBits-1:0] addr, pushVal, jmpTarget;
  logic [7:0]             waitN;
  logic [IdxBits-1:0]     topIdx, pushIdx;
  logic                   stackFull, stackEmpty;
  logic                   jmpReq, stopReq, doPush, doPop, setFault, loadWait;

  assign opcode     = Instr[15:12];
  assign addr       = Instr[CounterBits-1:0];
  assign waitN      = Instr[7:0];
  assign pushVal    = PC_Counter + CounterBits'(1);
  assign stackFull  = (stackPtr == SpBits'(StackDepth));
  assign stackEmpty = (stackPtr == '0);
  assign topIdx     = IdxBits'(stackPtr - SpBits'(1));
  assign pushIdx    = IdxBits'(stackPtr);

  always_comb begin
    jmpReq    = 1'b0;
    stopReq   = 1'b0;
    jmpTarget = '0;
    doPush    = 1'b0;
    doPop     = 1'b0;
    setFault  = 1'b0;
    loadWait  = 1'b0;
    nextState = state;
    case (state)
      StRun: begin
        case (opcode)
          4'd1: begin
            jmpReq    = 1'b1;
            jmpTarget = addr;
          end
          4'd2: begin
            jmpReq    = ALU_Zero;
            jmpTarget = ALU_Zero ? addr : '0;
          end
          4'd3: begin
            if (stackFull) begin
              stopReq   = 1'b1;
              setFault  = 1'b1;
              nextState = StHaltFault;
            end else begin
              jmpReq    = 1'b1;
              jmpTarget = addr;
              doPush    = 1'b1;
            end
          end
          4'd4: begin
            if (stackEmpty) begin
              stopReq   = 1'b1;
              setFault  = 1'b1;
              nextState = StHaltFault;
            end else begin
              jmpReq    = 1'b1;
              jmpTarget = stackMem[topIdx];
              doPop     = 1'b1;
            end
          end
          4'd5: begin
            // WAIT 0 falls through as a NOP
            if (waitN != 8'd0) begin
              stopReq   = 1'b1;
              loadWait  = 1'b1;
              nextState = StWait;
            end
          end
          4'd6: begin
            stopReq   = 1'b1;
            nextState = StHaltOp;
          end
          default: ;
        endcase
      end
      StWait: begin
        stopReq = (waitCnt != 8'd0);
        if (waitCnt == 8'd0) nextState = StRun;
      end
      StHaltOp: begin
        stopReq = ~Resume;
        if (Resume) nextState = StRun;
      end
      default: stopReq = 1'b1;
    endcase
  end

  // Reset must silence the combinational outputs even though Instr may still decode
  assign PC_SetJmp  = jmpReq & ~CPU_SetReset;
  assign PC_SetStop = stopReq & ~CPU_SetReset;
  assign PC_JMPAddr = CPU_SetReset ? '0 : jmpTarget;
  assign Halted     = ~CPU_SetReset & ((state == StHaltOp) || (state == StHaltFault));

  always_ff @(posedge CLK or posedge CPU_SetReset) begin
    if (CPU_SetReset) begin
      state      <= StRun;
      stackPtr   <= '0;
      waitCnt    <= '0;
      StackFault <= 1'b0;
    end else begin
      state <= nextState;
      if (doPush)     stackPtr <= stackPtr + SpBits'(1);
      else if (doPop) stackPtr <= stackPtr - SpBits'(1);
      if (setFault) StackFault <= 1'b1;
      if (loadWait)
        waitCnt <= waitN - 8'd1;
      else if ((state == StWait) && (waitCnt != 8'd0))
        waitCnt <= waitCnt - 8'd1;
    end
  end

  // Return addresses are not reset; only the pointer decides validity
  always_ff @(posedge CLK) begin
    if (doPush) stackMem[pushIdx] <= pushVal;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the external PC counter, predicts the per-cycle PC trace
// from instruction-level semantics and compares it through a scoreboard queue.
module tb_pc_sequencer;
  localparam int Depth = 4;
  localparam int MaxCyc = 256;

  logic        CLK = 1'b0;
  logic        CPU_SetReset = 1'b1;
  logic [5:0]  PC_Counter;
  logic [15:0] Instr;
  logic        ALU_Zero = 1'b0;
  logic        Resume = 1'b0;
  logic        PC_SetJmp, PC_SetStop, Halted, StackFault;
  logic [5:0]  PC_JMPAddr;

  logic [15:0] prog [64];
  bit          aluz [MaxCyc];
  bit          resumeArr [MaxCyc];

  typedef struct {int pc; bit halted; bit fault;} exp_t;
  exp_t expQ[$];
  int   mc, mNcyc;
  int   checks = 0, errors = 0;

  pc_sequencer #(.CounterBits(6), .StackDepth(Depth)) dut (
    .CLK(CLK), .CPU_SetReset(CPU_SetReset), .PC_Counter(PC_Counter), .Instr(Instr),
    .ALU_Zero(ALU_Zero), .Resume(Resume), .PC_SetJmp(PC_SetJmp), .PC_JMPAddr(PC_JMPAddr),
    .PC_SetStop(PC_SetStop), .Halted(Halted), .StackFault(StackFault)
  );

  always #5 CLK = ~CLK;

  assign Instr = prog[PC_Counter];

  // External PC counter driven by the sequencer's controls
  always @(posedge CLK or posedge CPU_SetReset) begin
    if (CPU_SetReset)    PC_Counter <= '0;
    else if (PC_SetJmp)  PC_Counter <= PC_JMPAddr;
    else if (!PC_SetStop) PC_Counter <= PC_Counter + 6'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void put(input int p, input bit h, input bit f);
    exp_t e;
    if (mc < mNcyc) begin
      e.pc = p; e.halted = h; e.fault = f;
      expQ.push_back(e);
    end
    mc++;
  endfunction

  function automatic void faultForever(input int p);
    put(p, 1'b0, 1'b0);
    while (mc < mNcyc) put(p, 1'b1, 1'b1);
  endfunction

  // Instruction-level reference: how many cycles each instruction occupies and where the PC goes
  task automatic buildExpected(input int ncyc);
    int pc, op, addr, n;
    int stk[$];
    logic [15:0] ins;
    bit r;
    pc = 0; mc = 0; mNcyc = ncyc;
    expQ.delete();
    while (mc < ncyc) begin
      ins = prog[pc];
      op = int'(ins[15:12]); addr = int'(ins[5:0]); n = int'(ins[7:0]);
      case (op)
        1: begin put(pc, 0, 0); pc = addr; end
        2: begin r = aluz[mc]; put(pc, 0, 0); pc = r ? addr : (pc + 1) % 64; end
        3: if (stk.size() == Depth) faultForever(pc);
           else begin put(pc, 0, 0); stk.push_back((pc + 1) % 64); pc = addr; end
        4: if (stk.size() == 0) faultForever(pc);
           else begin put(pc, 0, 0); pc = stk.pop_back(); end
        5: begin
          for (int k = 0; k <= n; k++) put(pc, 0, 0);
          pc = (pc + 1) % 64;
        end
        6: begin
          put(pc, 0, 0);
          r = 1'b0;
          while (!r && mc < ncyc) begin
            r = resumeArr[mc];
            put(pc, 1, 0);
          end
          pc = (pc + 1) % 64;
        end
        default: begin put(pc, 0, 0); pc = (pc + 1) % 64; end
      endcase
    end
  endtask

  task automatic runEpisode(input int ncyc);
    buildExpected(ncyc);
    fork
      begin
        for (int c = 0; c < ncyc; c++) begin
          ALU_Zero = aluz[c];
          Resume   = resumeArr[c];
          @(posedge CLK);
          #1;
        end
      end
      begin
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
          @(negedge CLK);
          if (expQ.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_empty cycle=%0d", c);
          end else begin
            e = expQ.pop_front();
            check("pc", 32'(PC_Counter), e.pc);
            check("halted", 32'(Halted), 32'(e.halted));
            check("stack_fault", 32'(StackFault), 32'(e.fault));
          end
        end
      end
    join
  endtask

  // Asynchronous reset mid-cycle; outputs must clear immediately regardless of prior state
  task automatic doReset();
    @(negedge CLK);
    #2;
    ALU_Zero = 1'b1;
    Resume = 1'b0;
    CPU_SetReset = 1'b1;
    #1;
    check("rst_setjmp", 32'(PC_SetJmp), 0);
    check("rst_setstop", 32'(PC_SetStop), 0);
    check("rst_jmpaddr", 32'(PC_JMPAddr), 0);
    check("rst_halted", 32'(Halted), 0);
    check("rst_fault", 32'(StackFault), 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    CPU_SetReset = 1'b0;
  endtask

  task automatic randCtl();
    for (int c = 0; c < MaxCyc; c++) begin
      aluz[c] = 1'($urandom_range(0, 1));
      resumeArr[c] = ($urandom_range(0, 9) < 3);
    end
  endtask

  task automatic fillNop();
    for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
  endtask

  task automatic genProg();
    int r;
    logic [3:0] op;
    logic [11:0] low;
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 99);
      low = 12'($urandom);
      if (r < 35)      op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(7, 15));
      else if (r < 55) op = 4'd1;
      else if (r < 65) op = 4'd2;
      else if (r < 75) op = 4'd3;
      else if (r < 82) op = 4'd4;
      else if (r < 92) begin
        op = 4'd5;
        low[7:0] = 8'($urandom_range(0, 4));
      end
      else op = 4'd6;
      prog[i] = {op, low};
    end
  endtask

  initial begin
    // Jumps, WAIT 3 at 10, WAIT 0 at 11, HALT at 7, JMP 18 at 5
    fillNop();
    prog[0] = 16'h100A; prog[10] = 16'h5003; prog[11] = 16'h5000;
    prog[12] = 16'h1007; prog[7] = 16'h6000; prog[8] = 16'h1005; prog[5] = 16'h1012;
    randCtl();
    doReset();
    runEpisode(150);

    // CALL 4 from 63 pushes 0, RET at 4 returns to 0
    fillNop();
    prog[0] = 16'h103F; prog[63] = 16'h3004; prog[4] = 16'h4000;
    randCtl();
    doReset();
    runEpisode(40);

    // RET on empty stack right after reset
    fillNop();
    prog[0] = 16'h4000;
    randCtl();
    doReset();
    runEpisode(20);

    // Five nested CALLs overflow a four-entry stack
    fillNop();
    for (int i = 0; i < 5; i++) prog[i] = 16'h3000 | 16'(i + 1);
    randCtl();
    doReset();
    runEpisode(20);

    // WAIT 5 interrupted by reset mid-count
    fillNop();
    prog[0] = 16'h5005;
    randCtl();
    doReset();
    runEpisode(3);
    check("mid_wait_stop", 32'(PC_SetStop), 1);

    for (int ep = 0; ep < 6; ep++) begin
      genProg();
      randCtl();
      doReset();
      runEpisode(200);
    end
    doReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
